// File: rtl/bioz_sweep_capture_if.sv
// Result handshake bundle between the sweep capture block and the downstream logger.
interface bioz_sweep_capture_if #(
  parameter int ADC_W = 10
);
  logic             Res_Valid;
  logic             Res_Ready;
  logic [3:0]       Res_Fsel;
  logic [ADC_W-1:0] Res_Data;

  modport master (
    output Res_Valid,
    output Res_Fsel,
    output Res_Data,
    input  Res_Ready
  );

  modport slave (
    input  Res_Valid,
    input  Res_Fsel,
    input  Res_Data,
    output Res_Ready
  );
endinterface

// File: rtl/bioz_sweep_capture.sv
// BioZ sweep capture: discards settling conversions after every Fsel step,
// averages 2^AVG_LOG2 conversions and offers one tagged result per step.
// Optional build macro BIOZ_CAPTURE_FSEL_SYNC_EN adds a two-flop Fsel synchronizer.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | after reset; latches Fsel on the next clock
// S_SETTLE | discarding SETTLE_N conversions while the front end settles
// S_ACCUM  | summing 2^AVG_LOG2 conversions
// S_DONE   | average produced; waiting for the next Fsel step
module bioz_sweep_capture #(
  parameter int ADC_W    = 10,
  parameter int AVG_LOG2 = 3,
  parameter int SETTLE_N = 2
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic [3:0]            Fsel,
  input  logic                  ADC_Done,
  input  logic [ADC_W-1:0]      ADC_Data,
  bioz_sweep_capture_if.master  res,
  output logic                  Overrun,
  output logic                  Busy
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 + 1 > 4) ? AVG_LOG2 + 1 : 4;
  localparam logic [CNT_W-1:0] AVG_LD    = CNT_W'(1 << AVG_LOG2);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_N);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_DONE} state_t;

  // Entry state after a step: skip SETTLE entirely when nothing is discarded.
  localparam state_t FIRST_ST = (SETTLE_N == 0) ? S_ACCUM : S_SETTLE;
  localparam logic [CNT_W-1:0] FIRST_LD = (SETTLE_N == 0) ? AVG_LD : SETTLE_LD;

  state_t           state_q, state_d;
  logic [3:0]       cur_fsel_q, cur_fsel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             pend_q, pend_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       res_fsel_q, res_fsel_d;
  logic [ADC_W-1:0] res_data_q, res_data_d;
  logic             overrun_q, overrun_d;
  logic [3:0]       fsel_in;
  logic             step;

`ifdef BIOZ_CAPTURE_FSEL_SYNC_EN
  logic [3:0] fsel_meta_q, fsel_sync_q;

  // Two-flop synchronizer for the sequencer's frequency select.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      fsel_meta_q <= '0;
      fsel_sync_q <= '0;
    end else begin
      fsel_meta_q <= Fsel;
      fsel_sync_q <= fsel_meta_q;
    end
  end

  assign fsel_in = fsel_sync_q;
`else
  assign fsel_in = Fsel;
`endif

  // A step is any Fsel difference once a frequency has been latched; wrap is not special.
  assign step = (state_q != S_IDLE) && (fsel_in != cur_fsel_q);

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      cur_fsel_q  <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      pend_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_fsel_q  <= '0;
      res_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_fsel_q  <= cur_fsel_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      res_valid_q <= res_valid_d;
      res_fsel_q  <= res_fsel_d;
      res_data_q  <= res_data_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic; a step change overrides any conversion in the same cycle.
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE || step) begin
      state_d = FIRST_ST;
    end else begin
      case (state_q)
        S_SETTLE: if (ADC_Done && cnt_q == CNT_ONE) state_d = S_ACCUM;
        S_ACCUM:  if (ADC_Done && cnt_q == CNT_ONE) state_d = S_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    Busy = (state_q == S_SETTLE) || (state_q == S_ACCUM);
  end

  // Down-counters for discards and samples, accumulator, and finished-average strobe.
  always_comb begin
    cur_fsel_d = cur_fsel_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    pend_d     = 1'b0;
    if (state_q == S_IDLE || step) begin
      cur_fsel_d = fsel_in;
      cnt_d      = FIRST_LD;
      acc_d      = '0;
    end else if (ADC_Done) begin
      if (state_q == S_SETTLE) begin
        cnt_d = (cnt_q == CNT_ONE) ? AVG_LD : cnt_q - CNT_ONE;
      end else if (state_q == S_ACCUM) begin
        acc_d  = acc_q + ACC_W'(ADC_Data);
        cnt_d  = cnt_q - CNT_ONE;
        pend_d = (cnt_q == CNT_ONE);
      end
    end
  end

  // Single-entry output buffer; a finished average is dropped only if the slot stays full.
  always_comb begin
    res_valid_d = res_valid_q;
    res_fsel_d  = res_fsel_q;
    res_data_d  = res_data_q;
    overrun_d   = 1'b0;
    if (res_valid_q && res.Res_Ready) res_valid_d = 1'b0;
    if (pend_q) begin
      if (res_valid_q && !res.Res_Ready) begin
        overrun_d = 1'b1;
      end else begin
        res_valid_d = 1'b1;
        res_fsel_d  = cur_fsel_q;
        res_data_d  = ADC_W'(acc_q >> AVG_LOG2);
      end
    end
  end

  assign res.Res_Valid = res_valid_q;
  assign res.Res_Fsel  = res_fsel_q;
  assign res.Res_Data  = res_data_q;
  assign Overrun       = overrun_q;

endmodule

// File: tb/tb_bioz_sweep_capture.sv
// Scoreboard bench for bioz_sweep_capture (AVG_LOG2=2, SETTLE_N=1).
module tb_bioz_sweep_capture;
  localparam int ADC_W = 10;
`ifdef BIOZ_CAPTURE_FSEL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic             Clk = 1'b0;
  logic             Resetn = 1'b0;
  logic [3:0]       Fsel = 4'd5;
  logic             ADC_Done = 1'b0;
  logic [ADC_W-1:0] ADC_Data = '0;
  logic             Overrun;
  logic             Busy;

  bioz_sweep_capture_if #(.ADC_W(ADC_W)) rif ();

  bioz_sweep_capture #(.ADC_W(ADC_W), .AVG_LOG2(2), .SETTLE_N(1)) dut (
    .Clk(Clk), .Resetn(Resetn), .Fsel(Fsel), .ADC_Done(ADC_Done), .ADC_Data(ADC_Data),
    .res(rif), .Overrun(Overrun), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0]       fsel;
    logic [ADC_W-1:0] data;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ovr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when valid and ready are both high here.
  always @(negedge Clk) begin
    res_t r;
    if (Resetn) begin
      if (Overrun) ovr_cnt++;
      if (rif.Res_Valid && rif.Res_Ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got fsel=%0d data=%0d, required no result",
                   rif.Res_Fsel, rif.Res_Data);
        end else begin
          r = exp_q.pop_front();
          check("res_fsel", 32'(rif.Res_Fsel), 32'(r.fsel));
          check("res_data", 32'(rif.Res_Data), 32'(r.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic adc(input int d);
    ADC_Data = ADC_W'(d);
    ADC_Done = 1'b1;
    tick();
    ADC_Done = 1'b0;
  endtask

  task automatic feed(input int d);
    adc(d);
    tick();
  endtask

  task automatic expect_res(input int f, input int d);
    res_t r;
    r.fsel = 4'(f);
    r.data = ADC_W'(d);
    exp_q.push_back(r);
  endtask

  task automatic check_outs(input string tag, input int v, input int f, input int d, input int o);
    check({tag, "_valid"}, 32'(rif.Res_Valid), 32'(v));
    check({tag, "_fsel"}, 32'(rif.Res_Fsel), 32'(f));
    check({tag, "_data"}, 32'(rif.Res_Data), 32'(d));
    check({tag, "_overrun"}, 32'(Overrun), 32'(o));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rif.Res_Ready = 1'b0;
    repeat (3) tick();
    check_outs("reset", 0, 0, 0, 0);
    check("reset_busy", 32'(Busy), 0);
    Resetn = 1'b1;

    // Basic average with Fsel=5: 100 discarded, (10+20+30+41)>>2 = 25.
    repeat (5) tick();
    check("basic_busy", 32'(Busy), 1);
    feed(100); feed(10); feed(20); feed(30);
    expect_res(5, 25);
    adc(41);
    check("basic_latency_low", 32'(rif.Res_Valid), 0);
    tick();
    check_outs("basic", 1, 5, 25, 0);
    check("basic_done_busy", 32'(Busy), 0);
    feed(1); feed(1); feed(1);
    check_outs("basic_hold", 1, 5, 25, 0);
    check("basic_no_overrun", 32'(ovr_cnt), 0);

    // Backpressure: step 5->4, measure detection latency, then a dropped result.
    Fsel = 4'd4;
    n = 0;
    while (!Busy && n < 10) begin
      tick();
      n++;
    end
    check("step_detect_cycles", 32'(n), 32'(1 + SYNC_LAT));
    repeat (3) tick();
    feed(7); feed(60); feed(60); feed(60);
    adc(60);
    tick();
    check_outs("overrun", 1, 5, 25, 1);
    tick();
    check_outs("overrun_end", 1, 5, 25, 0);
    rif.Res_Ready = 1'b1;
    tick();
    check("drain_valid", 32'(rif.Res_Valid), 0);

    // Abort: Fsel 6 with two counted samples, then step to 3; 200 must be discarded.
    Fsel = 4'd6;
    repeat (5) tick();
    feed(0); feed(8); feed(8);
    Fsel = 4'd3;
    repeat (5) tick();
    check("abort_busy", 32'(Busy), 1);
    feed(200); feed(4); feed(4); feed(8);
    expect_res(3, 6);
    feed(8);
    repeat (2) tick();

    // Full scale and truncation.
    Fsel = 4'd7;
    repeat (5) tick();
    feed(5); feed(1023); feed(1023); feed(1023);
    expect_res(7, 1023);
    feed(1023);
    Fsel = 4'd8;
    repeat (5) tick();
    feed(9); feed(0); feed(0); feed(0);
    expect_res(8, 0);
    feed(3);
    repeat (2) tick();

    // Handshake in the same cycle a new result finishes: (40+40+40+44)>>2 = 41.
    rif.Res_Ready = 1'b0;
    Fsel = 4'd9;
    repeat (5) tick();
    feed(1); feed(16); feed(16); feed(16);
    expect_res(9, 16);
    feed(16);
    check("held9_valid", 32'(rif.Res_Valid), 1);
    Fsel = 4'd10;
    repeat (5) tick();
    feed(1); feed(40); feed(40); feed(40);
    expect_res(10, 41);
    adc(44);
    rif.Res_Ready = 1'b1;
    tick();
    check_outs("same_cycle", 1, 10, 41, 0);
    tick();
    check("same_cycle_drain", 32'(rif.Res_Valid), 0);

    // Step change coincident with ADC_Done: the 1000 sample must not count anywhere.
    Fsel = 4'd11;
    repeat (5) tick();
    feed(1); feed(12); feed(12); feed(12);
    Fsel = 4'd12;
    repeat (SYNC_LAT) tick();
    feed(1000);
    repeat (5) tick();
    feed(50); feed(20); feed(20); feed(20);
    expect_res(12, 20);
    feed(20);
    repeat (2) tick();

    // Async reset mid-ACCUM with a pending result.
    rif.Res_Ready = 1'b0;
    Fsel = 4'd13;
    repeat (5) tick();
    feed(1); feed(4); feed(4); feed(4); feed(4);
    check("pre_reset_valid", 32'(rif.Res_Valid), 1);
    Fsel = 4'd14;
    repeat (5) tick();
    feed(1); feed(9); feed(9);
    #2;
    Resetn = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 0, 0);
    check("async_reset_busy", 32'(Busy), 0);
    tick();
    Resetn = 1'b1;
    rif.Res_Ready = 1'b1;
    repeat (5) tick();
    feed(200); feed(80); feed(80); feed(80);
    check("post_reset_partial", 32'(rif.Res_Valid), 0);
    expect_res(14, 80);
    adc(80);
    tick();
    check("post_reset_valid", 32'(rif.Res_Valid), 1);
    repeat (4) tick();

    check("queue_empty", 32'(exp_q.size()), 0);
    check("overrun_count", 32'(ovr_cnt), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bioz_sweep_capture.md
# bioz_sweep_capture

Receive-side counterpart to the BioZ digital stimulus sequencer. It watches the frequency-select word `Fsel` stepping through the bioimpedance sweep and discards the first conversions after each step while the analog front end settles. It then averages a fixed number of ADC conversions and hands one averaged result per frequency step, tagged with its `Fsel`, to the downstream logger over a valid/ready handshake.

## Interface
- `ADC_W`, default 10: ADC sample width.
- `AVG_LOG2`, default 3: log2 of the number of averaged samples per step (8).
- `SETTLE_N`, default 2: number of conversions discarded after each `Fsel` change; range 0–15.
- `Clk` input 1: single clock; all logic on the rising edge.
- `Resetn` input 1: asynchronous, active-low reset.
- `Fsel` input 4: current sweep frequency select from the stimulus sequencer.
- `ADC_Done` input 1: one-cycle pulse marking a valid conversion.
- `ADC_Data` input ADC_W: conversion value, sampled only when `ADC_Done` = 1.
- `Res_Valid` output 1: averaged result available.
- `Res_Ready` input 1: downstream accepts the result.
- `Res_Fsel` output 4: `Fsel` the result belongs to.
- `Res_Data` output ADC_W: averaged value.
- `Overrun` output 1: one-cycle pulse when a finished result is dropped.
- `Busy` output 1: high in SETTLE or ACCUM.

## Operation
- States: IDLE, SETTLE, ACCUM, DONE.
- IDLE: entered on reset. On the next clock, latch `Fsel` into `cur_fsel`, clear the counters, and go to SETTLE.
- SETTLE: each `ADC_Done` increments the discard count. After `SETTLE_N` discards, go to ACCUM. If `SETTLE_N` = 0, go directly to ACCUM.
- ACCUM: each `ADC_Done` adds `ADC_Data` to an accumulator of width ADC_W+AVG_LOG2, which cannot overflow. After 2^AVG_LOG2 samples, compute `result = acc >> AVG_LOG2` (truncating) and go to DONE.
- DONE: no further sampling. Wait for an `Fsel` change.
- Step change: in SETTLE, ACCUM or DONE, `Fsel` ≠ `cur_fsel` causes the block to:
  - latch the new `Fsel`;
  - clear the accumulator and counters;
  - go to SETTLE.
  
  A partial average is abandoned silently, with no result and no `Overrun`.
- Simultaneous step change and `ADC_Done`: the step change wins and the sample is not counted.
- Output buffer, single entry:
  - A finished result loads `Res_Data`/`Res_Fsel` and sets `Res_Valid`.
  - If `Res_Valid` = 1 and `Res_Ready` = 0 when a new result finishes, the new result is dropped, the old one is held, and `Overrun` pulses for one cycle.
  - If the handshake completes in the same cycle a new result finishes, the new result loads, `Res_Valid` stays 1, and no `Overrun` is raised.
- `Res_Data`/`Res_Fsel` remain stable while `Res_Valid` = 1 and not accepted.

## Timing
- Reset values: `Res_Valid`=0, `Res_Data`=0, `Res_Fsel`=0, `Overrun`=0, `Busy`=0; state IDLE; accumulator and counters 0.
- Reset mid-operation: takes effect immediately (asynchronous). Everything returns to the reset values and any partial average or pending result is lost.
- `Res_Valid` rises on the clock edge after the edge that samples the final counted `ADC_Done`, i.e. one cycle of latency.
- Handshake: a transfer occurs on a rising edge where `Res_Valid`=1 and `Res_Ready`=1. `Res_Valid` is low the following cycle unless a new result loads in that same cycle.
- `Fsel` change detection: one cycle (compare against `cur_fsel`, registered). `Busy` follows the state register.
- `Fsel` wrap-around (0 → 15) is treated as an ordinary change.

## Configuration
- `BIOZ_CAPTURE_FSEL_SYNC_EN`:
  - Defined: `Fsel` passes through a two-flop synchronizer, reset to 0, before change detection and latching. This adds 2 cycles to step-change detection and to the IDLE latch.
  - Undefined: `Fsel` is treated as synchronous to `Clk` and used directly.

## Test plan
All scenarios use `AVG_LOG2`=2 and `SETTLE_N`=1 unless noted.
- Basic average: `Fsel`=5 constant; samples 100 (discarded), 10, 20, 30, 41 → `Res_Valid`=1 one cycle after the 4th counted pulse, `Res_Data`=25, `Res_Fsel`=5; no further results while `Fsel` stays 5.
- Backpressure overrun: `Res_Ready`=0 holds the 25 result; `Fsel` 5→4; feed 1 discard plus 4×60 → `Overrun` pulses for 1 cycle, outputs stay 25/5; raising `Res_Ready` clears `Res_Valid` next cycle.
- Abort: `Fsel` 4→3 after 2 counted samples in ACCUM → no result, state returns to SETTLE, `Busy`=1; next complete set yields `Res_Fsel`=3.
- Width/saturation: 4×1023 with `ADC_W`=10 → `Res_Data`=1023, no wrap; 0,0,0,3 → `Res_Data`=0 (truncation).
- Simultaneous events:
  - Handshake in the same cycle as a new result → new value loads, `Res_Valid` stays 1, `Overrun`=0.
  - `Fsel` change in the same cycle as `ADC_Done` → that sample is not counted.
- Async reset mid-ACCUM with `Res_Valid`=1 → all outputs 0 immediately, IDLE; after release, a fresh `SETTLE_N`+4 samples are needed. Repeat the basic-average scenario with `BIOZ_CAPTURE_FSEL_SYNC_EN` defined and check the added 2-cycle detection delay.
